// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch slice.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] OPC_JAL = 7'h6F;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FS_FETCH  = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular buffer of fetched {pc, instr} entries with push, pop and flush.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  fetch_entry_t       i_wdata,
  output fetch_entry_t       o_head,
  output logic [CNT_W-1:0]   o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointers wrap naturally because DEPTH is a power of two. When full with
  // a same-cycle pop, the write lands on the slot being read out this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{pc: '0, instr: NOP_WORD};
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM, buffers
// {instr, pc} for decode, flushes on redirect and parks on a self-loop jal.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 6,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_dout,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic              halted
);

  // Decode handshake: a transfer completes on any rising edge where
  // out_valid and out_ready are both high; out_valid never depends on out_ready.

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_halt_jal;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_wdata;

  assign rom_addr   = r_pc[ADDR_W+1:2];
  assign out_valid  = (w_count != '0);
  assign out_instr  = w_head.instr;
  assign out_pc     = w_head.pc;
  assign halted     = (r_state == FS_HALTED);
  assign w_pop      = out_valid & out_ready;
  assign w_halt_jal = (rom_dout[6:0] == OPC_JAL) && (rom_dout[31:12] == 20'd0);
  assign w_wdata    = '{pc: r_pc, instr: rom_dout};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = FS_FETCH;
      w_pc_nxt    = redirect_pc & ~32'h3;
    end else if (r_state == FS_FETCH &&
                 (w_count != CNT_W'(DEPTH) || w_pop)) begin
      w_push = 1'b1;
      // A jal to itself would refill the buffer forever; keep pc on it.
      if (w_halt_jal) begin
        w_state_nxt = FS_HALTED;
      end else begin
        w_pc_nxt = r_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FS_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_dout;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              halted;

  logic [31:0] rom [64];
  assign rom_dout = rom[rom_addr];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  // Reference model: the buffer is a queue of {pc, instr}; fetch is the
  // program-order walk from the last reset/redirect target.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          errors = 0;
  int          checks = 0;

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_halt = 0;
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc);
    bit pop, push;
    logic [31:0] w;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    pop  = (m_q.size() != 0) && out_ready;
    w    = rom[m_pc[7:2]];
    push = !m_halt && !rv && ((m_q.size() < DEPTH) || pop);
    if (rv) begin
      m_q.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_halt = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, w});
        if (w[6:0] == 7'h6F && w[31:12] == 20'd0) m_halt = 1;
        else m_pc += 32'd4;
      end
    end
    #1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b pc=%h instr=%h expected 0/0/0", out_valid, out_pc, out_instr);
    end
    checks++;
    if (rom_addr !== 6'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_addr_halt: got addr=%0d halted=%b expected 0/0", rom_addr, halted);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00003f37) begin
      errors++;
      $display("FAIL first_fetch: got valid=%b pc=%h instr=%h expected 1/0/00003f37", out_valid, out_pc, out_instr);
    end
    step(1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h02000fe7) begin
      errors++;
      $display("FAIL second_fetch: got valid=%b pc=%h instr=%h expected 1/4/02000fe7", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_addr;
    apply_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 32'h0);
      exp_addr = (k < 2) ? 6'(k) : 6'd2;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_addr !== exp_addr) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b pc=%h addr=%0d expected 1/0/%0d", k, out_valid, out_pc, rom_addr, exp_addr);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== rom[k]) begin
        errors++;
        $display("FAIL stall_release[%0d]: got valid=%b pc=%h instr=%h expected 1/%h/%h", k, out_valid, out_pc, out_instr, 32'(4 * k), rom[k]);
      end
      step(1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0022);
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 6'd8) begin
      errors++;
      $display("FAIL redirect_flush: got valid=%b addr=%0d expected 0/8", out_valid, rom_addr);
    end
    step(1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h00001c63) begin
      errors++;
      $display("FAIL redirect_target: got valid=%b pc=%h instr=%h expected 1/20/00001c63", out_valid, out_pc, out_instr);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(32'h20 + 4 * k)) begin
        errors++;
        $display("FAIL redirect_stream[%0d]: got valid=%b pc=%h expected 1/%h", k, out_valid, out_pc, 32'(32'h20 + 4 * k));
      end
    end
  endtask

  task automatic test_halt();
    logic [5:0] exp_addr;
    apply_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 32'h0);
      exp_addr = (k < 8) ? 6'(k) : 6'd7;
      checks++;
      if (halted !== (k >= 8) || rom_addr !== exp_addr) begin
        errors++;
        $display("FAIL halt_state[%0d]: got halted=%b addr=%0d expected %b/%0d", k, halted, rom_addr, (k >= 8), exp_addr);
      end
      checks++;
      if (k <= 8) begin
        if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 1)) || out_instr !== rom[k - 1]) begin
          errors++;
          $display("FAIL halt_stream[%0d]: got valid=%b pc=%h instr=%h expected 1/%h/%h", k, out_valid, out_pc, out_instr, 32'(4 * (k - 1)), rom[k - 1]);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_drained[%0d]: got valid=%b expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_redirect_halted();
    step(1'b1, 32'h0000_0008);
    checks++;
    if (halted !== 1'b0 || out_valid !== 1'b0 || rom_addr !== 6'd2) begin
      errors++;
      $display("FAIL unhalt: got halted=%b valid=%b addr=%0d expected 0/0/2", halted, out_valid, rom_addr);
    end
    step(1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h01c02623) begin
      errors++;
      $display("FAIL unhalt_target: got valid=%b pc=%h instr=%h expected 1/8/01c02623", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: got valid=%b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b pc=%h instr=%h expected 0/0/0", out_valid, out_pc, out_instr);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== rom[0]) begin
      errors++;
      $display("FAIL mid_restart: got valid=%b pc=%h instr=%h expected 1/0/%h", out_valid, out_pc, out_instr, rom[0]);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    step(1'b1, 32'h0000_00fc);
    checks++;
    if (rom_addr !== 6'd63) begin
      errors++;
      $display("FAIL wrap_addr63: got %0d expected 63", rom_addr);
    end
    step(1'b0, 32'h0);
    checks++;
    if (rom_addr !== 6'd0 || out_pc !== 32'hfc || out_instr !== rom[63]) begin
      errors++;
      $display("FAIL wrap_addr0: got addr=%0d pc=%h instr=%h expected 0/fc/%h", rom_addr, out_pc, out_instr, rom[63]);
    end
    step(1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== rom[0]) begin
      errors++;
      $display("FAIL wrap_next: got valid=%b pc=%h instr=%h expected 1/100/%h", out_valid, out_pc, out_instr, rom[0]);
    end
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] rpc;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (rom_addr !== m_pc[7:2] || halted !== m_halt || out_valid !== (m_q.size() != 0)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got addr=%0d halted=%b valid=%b expected %0d/%b/%b", n, rom_addr, halted, out_valid, m_pc[7:2], m_halt, (m_q.size() != 0));
      end
      if (m_q.size() != 0) begin
        checks++;
        if (out_pc !== m_q[0][63:32] || out_instr !== m_q[0][31:0]) begin
          errors++;
          $display("FAIL rand_head[%0d]: got pc=%h instr=%h expected %h/%h", n, out_pc, out_instr, m_q[0][63:32], m_q[0][31:0]);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 99) == 0) apply_reset();
      else step(rv, rpc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = ($urandom() & 32'hffff_ff80) | 32'h0000_0013;
    end
    rom[0] = 32'h00003f37;
    rom[1] = 32'h02000fe7;
    rom[2] = 32'h01c02623;
    rom[7] = 32'h00000fef;
    rom[8] = 32'h00001c63;

    test_reset();
    test_backpressure();
    test_redirect();
    test_halt();
    test_redirect_halted();
    test_reset_midstream();
    test_wrap();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
